// File: rtl/ahb_bus_pkg.sv
// Shared types for the AHB-Lite bus interconnect with watchdog.
// Transfer types, response codes, error codes and FSM states.
package ahb_bus_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_UNMAPPED = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_SLAVE    = 2'b11
  } err_type_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SLV  = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } bus_state_t;

endpackage

// File: rtl/ahb_bus_wdt.sv
// Data-phase watchdog: counts stalled cycles, pulses expired_o on the
// TIMEOUT-th consecutive stalled cycle. TIMEOUT=0 removes the counter.
module ahb_bus_wdt #(
  parameter int TIMEOUT = 256
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic clr_i,
  input  logic cnt_en_i,
  output logic expired_o
);

  if (TIMEOUT > 0) begin : g_cnt
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // next count: clear wins, saturate at TIMEOUT
    always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
        cnt_d = '0;
      end else if (cnt_en_i && (cnt_q != CW'(TIMEOUT))) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end

    // stall counter register
    always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) cnt_q <= '0;
      else          cnt_q <= cnt_d;
    end

    assign expired_o = cnt_en_i && !clr_i && (cnt_q == CW'(TIMEOUT - 1));
  end else begin : g_none
    assign expired_o = 1'b0;
  end

endmodule

// File: rtl/ahb_bus_wd.sv
// Single-master AHB-Lite interconnect: priority address decode, default
// slave, per-transfer watchdog with slave quarantine, sticky error capture.
module ahb_bus_wd
  import ahb_bus_pkg::*;
#(
  parameter int                   NSLAVES      = 4,
  parameter int                   DW           = 32,
  parameter int                   AW           = 32,
  parameter logic [NSLAVES*AW-1:0] S_ADDR_START = '0,
  parameter logic [NSLAVES*AW-1:0] S_ADDR_END   = '0,
  parameter int                   TIMEOUT      = 256
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [AW-1:0]         M_HADDR,
  input  logic [1:0]            M_HTRANS,
  input  logic                  M_HWRITE,
  input  logic [2:0]            M_HSIZE,
  input  logic [DW-1:0]         M_HWDATA,
  output logic [DW-1:0]         M_HRDATA,
  output logic                  M_HREADY,
  output logic                  M_HRESP,
  output logic [NSLAVES-1:0]    S_HSEL,
  output logic [AW-1:0]         S_HADDR,
  output logic [1:0]            S_HTRANS,
  output logic                  S_HWRITE,
  output logic [2:0]            S_HSIZE,
  output logic [DW-1:0]         S_HWDATA,
  output logic                  S_HREADY,
  input  logic [NSLAVES-1:0]    S_HREADYOUT,
  input  logic [NSLAVES-1:0]    S_HRESP,
  input  logic [NSLAVES*DW-1:0] S_HRDATA,
  input  logic                  err_clr,
  output logic                  err_valid,
  output logic [1:0]            err_type,
  output logic [AW-1:0]         err_addr,
  output logic [NSLAVES-1:0]    quarantine
);

  localparam int SW = $clog2(NSLAVES + 1);
  localparam logic [SW-1:0] DEF_SEL = SW'(NSLAVES);

  bus_state_t       state_q, state_d, acc_next_s;
  logic [SW-1:0]    dsel_q, hit_idx_s;
  logic             dact_q, hit_s;
  logic [AW-1:0]    daddr_q;
  logic [NSLAVES-1:0] quar_q, quar_d;
  logic             slv_rdy_s, slv_resp_s;
  logic [DW-1:0]    slv_rdata_s;
  logic             m_hready_s, m_hresp_s;
  logic [DW-1:0]    m_hrdata_s;
  logic             wdt_exp_s, wdt_en_s, trig_s;
  err_type_t        trig_type_s, err_type_q, err_type_d;
  logic             err_valid_q, err_valid_d;
  logic [AW-1:0]    err_addr_q, err_addr_d;

  // priority decode: scan downwards so the lowest matching index wins
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = DEF_SEL;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if (((S_ADDR_START[i*AW +: AW] != '0) || (S_ADDR_END[i*AW +: AW] != '0)) &&
          (M_HADDR >= S_ADDR_START[i*AW +: AW]) && (M_HADDR <= S_ADDR_END[i*AW +: AW]) &&
          !quar_q[i]) begin
        hit_s     = 1'b1;
        hit_idx_s = SW'(i);
      end else begin
        hit_s     = hit_s;
      end
    end
    for (int i = 0; i < NSLAVES; i++) begin
      S_HSEL[i] = hit_s && (hit_idx_s == SW'(i));
    end
  end

  // response mux from the data-phase slave
  always_comb begin
    slv_rdy_s   = 1'b1;
    slv_resp_s  = HRESP_OKAY;
    slv_rdata_s = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (dsel_q == SW'(i)) begin
        slv_rdy_s   = S_HREADYOUT[i];
        slv_resp_s  = S_HRESP[i];
        slv_rdata_s = S_HRDATA[i*DW +: DW];
      end else begin
        slv_rdy_s   = slv_rdy_s;
      end
    end
  end

  // state reached when the current address phase is accepted
  always_comb begin
    if (M_HTRANS[1]) acc_next_s = hit_s ? ST_SLV : ST_ERR1;
    else             acc_next_s = ST_IDLE;
  end

  // FSM next state and master-side response
  always_comb begin
    state_d    = state_q;
    m_hready_s = 1'b1;
    m_hresp_s  = HRESP_OKAY;
    m_hrdata_s = '0;
    case (state_q)
      ST_IDLE: state_d = acc_next_s;
      ST_SLV: begin
        m_hready_s = slv_rdy_s;
        m_hresp_s  = slv_resp_s;
        m_hrdata_s = slv_rdata_s;
        if (wdt_exp_s)      state_d = ST_ERR1;
        else if (slv_rdy_s) state_d = acc_next_s;
        else                state_d = ST_SLV;
      end
      ST_ERR1: begin
        m_hready_s = 1'b0;
        m_hresp_s  = HRESP_ERROR;
        state_d    = ST_ERR2;
      end
      ST_ERR2: begin
        m_hresp_s  = HRESP_ERROR;
        state_d    = acc_next_s;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wdt_en_s = (state_q == ST_SLV) && !slv_rdy_s;

  ahb_bus_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .clr_i     (m_hready_s),
    .cnt_en_i  (wdt_en_s),
    .expired_o (wdt_exp_s)
  );

  // quarantine: a ready slave is released, a timed-out slave is excluded
  always_comb begin
    quar_d = quar_q & ~S_HREADYOUT;
    for (int i = 0; i < NSLAVES; i++) begin
      if (wdt_exp_s && (dsel_q == SW'(i))) quar_d[i] = 1'b1;
      else                                 quar_d[i] = quar_d[i];
    end
  end

  // error capture; an ERR1 cycle with the default slave selected is unmapped
  always_comb begin
    trig_s = (state_q == ST_ERR1) ||
             ((state_q == ST_SLV) && dact_q && slv_resp_s && !slv_rdy_s);
    if (state_q == ST_ERR1) trig_type_s = (dsel_q == DEF_SEL) ? ERR_UNMAPPED : ERR_TIMEOUT;
    else                    trig_type_s = ERR_SLAVE;
    err_valid_d = err_valid_q;
    err_type_d  = err_type_q;
    err_addr_d  = err_addr_q;
    if (trig_s && (!err_valid_q || err_clr)) begin
      err_valid_d = 1'b1;
      err_type_d  = trig_type_s;
      err_addr_d  = daddr_q;
    end else if (err_clr) begin
      err_valid_d = 1'b0;
      err_type_d  = ERR_NONE;
      err_addr_d  = '0;
    end else begin
      err_valid_d = err_valid_q;
    end
  end

  // state, data-phase, quarantine and error registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      dsel_q      <= '0;
      dact_q      <= 1'b0;
      daddr_q     <= '0;
      quar_q      <= '0;
      err_valid_q <= 1'b0;
      err_type_q  <= ERR_NONE;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      quar_q      <= quar_d;
      err_valid_q <= err_valid_d;
      err_type_q  <= err_type_d;
      err_addr_q  <= err_addr_d;
      if (m_hready_s) begin
        dsel_q  <= hit_s ? hit_idx_s : DEF_SEL;
        dact_q  <= M_HTRANS[1];
        daddr_q <= M_HADDR;
      end
    end
  end

  assign M_HREADY   = m_hready_s;
  assign M_HRESP    = m_hresp_s;
  assign M_HRDATA   = m_hrdata_s;
  assign S_HREADY   = m_hready_s;
  assign S_HADDR    = M_HADDR;
  assign S_HTRANS   = M_HTRANS;
  assign S_HWRITE   = M_HWRITE;
  assign S_HSIZE    = M_HSIZE;
  assign S_HWDATA   = M_HWDATA;
  assign err_valid  = err_valid_q;
  assign err_type   = err_type_q;
  assign err_addr   = err_addr_q;
  assign quarantine = quar_q;

endmodule

// File: tb/tb_ahb_bus_wd.sv
// Directed cycle-vector bench for ahb_bus_wd: two slaves, TIMEOUT=8, plus
// a second instance with overlapping regions for decode priority.
module tb_ahb_bus_wd;
  import ahb_bus_pkg::*;

  localparam int NS = 2;
  localparam logic [63:0] ST_A = {32'h1000_0000, 32'h0000_0000};
  localparam logic [63:0] EN_A = {32'h1000_0FFF, 32'h0000_0FFF};
  localparam logic [63:0] ST_O = {32'h0000_0000, 32'h0000_0000};
  localparam logic [63:0] EN_O = {32'h0000_0FFF, 32'h0000_0FFF};
  localparam logic [31:0] D  = 32'hA5A5_0000;
  localparam logic [31:0] C  = 32'hCAFE_F00D;
  localparam logic [31:0] R1 = 32'h1111_2222;
  localparam logic [1:0]  N  = 2'b10;
  localparam logic [1:0]  I  = 2'b00;

  logic        HCLK, HRESETn;
  logic [31:0] M_HADDR, M_HWDATA, M_HRDATA, S_HADDR, S_HWDATA, err_addr, rd0;
  logic [1:0]  M_HTRANS, S_HTRANS, S_HSEL, S_HREADYOUT, S_HRESP, err_type, quarantine;
  logic        M_HWRITE, S_HWRITE, M_HREADY, M_HRESP, S_HREADY, err_clr, err_valid;
  logic [2:0]  M_HSIZE, S_HSIZE;
  logic [63:0] S_HRDATA;
  logic [31:0] o_hrdata, o_haddr, o_hwdata, o_eaddr;
  logic [1:0]  o_hsel, o_htrans, o_etype, o_quar;
  logic        o_hready, o_hresp, o_hwrite, o_sready, o_evalid;
  logic [2:0]  o_hsize;

  assign S_HRDATA = {R1, rd0};

  ahb_bus_wd #(.NSLAVES(NS), .DW(32), .AW(32), .S_ADDR_START(ST_A),
               .S_ADDR_END(EN_A), .TIMEOUT(8)) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS),
    .M_HWRITE(M_HWRITE), .M_HSIZE(M_HSIZE), .M_HWDATA(M_HWDATA),
    .M_HRDATA(M_HRDATA), .M_HREADY(M_HREADY), .M_HRESP(M_HRESP),
    .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE),
    .S_HSIZE(S_HSIZE), .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY),
    .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP), .S_HRDATA(S_HRDATA),
    .err_clr(err_clr), .err_valid(err_valid), .err_type(err_type),
    .err_addr(err_addr), .quarantine(quarantine));

  ahb_bus_wd #(.NSLAVES(NS), .DW(32), .AW(32), .S_ADDR_START(ST_O),
               .S_ADDR_END(EN_O), .TIMEOUT(8)) u_ovl (
    .HCLK(HCLK), .HRESETn(HRESETn), .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS),
    .M_HWRITE(M_HWRITE), .M_HSIZE(M_HSIZE), .M_HWDATA(M_HWDATA),
    .M_HRDATA(o_hrdata), .M_HREADY(o_hready), .M_HRESP(o_hresp),
    .S_HSEL(o_hsel), .S_HADDR(o_haddr), .S_HTRANS(o_htrans), .S_HWRITE(o_hwrite),
    .S_HSIZE(o_hsize), .S_HWDATA(o_hwdata), .S_HREADY(o_sready),
    .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP), .S_HRDATA(S_HRDATA),
    .err_clr(err_clr), .err_valid(o_evalid), .err_type(o_etype),
    .err_addr(o_eaddr), .quarantine(o_quar));

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr;  logic [1:0] trans; logic [1:0] rdy; logic [1:0] resp;
    logic [31:0] rd;    logic clr;
    logic e_rdy; logic e_resp; logic [31:0] e_rdata; logic [1:0] e_hsel;
    logic e_ev;  logic [1:0] e_et; logic [31:0] e_ea; logic [1:0] e_q;
  } vec_t;

  localparam int NV = 35;
  vec_t vecs[NV];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(logic [31:0] a, logic [1:0] t, logic [1:0] r, logic [1:0] rs,
                              logic [31:0] rd, logic c, logic er, logic ers, logic [31:0] erd,
                              logic [1:0] eh, logic ev, logic [1:0] et, logic [31:0] ea,
                              logic [1:0] eq);
    vec_t v;
    v.addr = a; v.trans = t; v.rdy = r; v.resp = rs; v.rd = rd; v.clr = c;
    v.e_rdy = er; v.e_resp = ers; v.e_rdata = erd; v.e_hsel = eh;
    v.e_ev = ev; v.e_et = et; v.e_ea = ea; v.e_q = eq;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic [1:0] r,
                       input logic [1:0] rs, input logic [31:0] rd, input logic c);
    M_HADDR = a; M_HTRANS = t; S_HREADYOUT = r; S_HRESP = rs; rd0 = rd; err_clr = c;
  endtask

  initial begin
    // read with 2 wait states
    vecs[0]  = mk(32'h10, N, 2'b11, 2'b00, D, 1'b0, 1'b1, 1'b0, 32'h0, 2'b01, 1'b0, 2'b00, 32'h0, 2'b00);
    vecs[1]  = mk(32'h10, I, 2'b10, 2'b00, D, 1'b0, 1'b0, 1'b0, D,     2'b01, 1'b0, 2'b00, 32'h0, 2'b00);
    vecs[2]  = mk(32'h10, I, 2'b10, 2'b00, D, 1'b0, 1'b0, 1'b0, D,     2'b01, 1'b0, 2'b00, 32'h0, 2'b00);
    vecs[3]  = mk(32'h10, I, 2'b11, 2'b00, C, 1'b0, 1'b1, 1'b0, C,     2'b01, 1'b0, 2'b00, 32'h0, 2'b00);
    // unmapped NONSEQ, then IDLE to the same address
    vecs[4]  = mk(32'h2000_0000, N, 2'b11, 2'b00, D, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, 32'h0, 2'b00);
    vecs[5]  = mk(32'h2000_0000, N, 2'b11, 2'b00, D, 1'b0, 1'b0, 1'b1, 32'h0, 2'b00, 1'b0, 2'b00, 32'h0, 2'b00);
    vecs[6]  = mk(32'h2000_0000, I, 2'b11, 2'b00, D, 1'b0, 1'b1, 1'b1, 32'h0, 2'b00, 1'b1, 2'b01, 32'h2000_0000, 2'b00);
    vecs[7]  = mk(32'h2000_0000, I, 2'b11, 2'b00, D, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 2'b01, 32'h2000_0000, 2'b00);
    vecs[8]  = mk(32'h0,         I, 2'b11, 2'b00, D, 1'b1, 1'b1, 1'b0, 32'h0, 2'b01, 1'b1, 2'b01, 32'h2000_0000, 2'b00);
    // slave1 timeout, quarantine, unmapped while quarantined, release
    vecs[9]  = mk(32'h1000_0000, N, 2'b11, 2'b00, D, 1'b0, 1'b1, 1'b0, 32'h0, 2'b10, 1'b0, 2'b00, 32'h0, 2'b00);
    for (int k = 10; k < 18; k++)
      vecs[k] = mk(32'h1000_0000, I, 2'b01, 2'b00, D, 1'b0, 1'b0, 1'b0, R1, 2'b10, 1'b0, 2'b00, 32'h0, 2'b00);
    vecs[18] = mk(32'h1000_0000, I, 2'b01, 2'b00, D, 1'b0, 1'b0, 1'b1, 32'h0, 2'b00, 1'b0, 2'b00, 32'h0, 2'b10);
    vecs[19] = mk(32'h1000_0000, N, 2'b01, 2'b00, D, 1'b0, 1'b1, 1'b1, 32'h0, 2'b00, 1'b1, 2'b10, 32'h1000_0000, 2'b10);
    vecs[20] = mk(32'h1000_0000, N, 2'b01, 2'b00, D, 1'b0, 1'b0, 1'b1, 32'h0, 2'b00, 1'b1, 2'b10, 32'h1000_0000, 2'b10);
    vecs[21] = mk(32'h1000_0000, I, 2'b01, 2'b00, D, 1'b0, 1'b1, 1'b1, 32'h0, 2'b00, 1'b1, 2'b10, 32'h1000_0000, 2'b10);
    vecs[22] = mk(32'h1000_0000, I, 2'b11, 2'b00, D, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1, 2'b10, 32'h1000_0000, 2'b10);
    vecs[23] = mk(32'h1000_0000, I, 2'b11, 2'b00, D, 1'b1, 1'b1, 1'b0, 32'h0, 2'b10, 1'b1, 2'b10, 32'h1000_0000, 2'b00);
    // back-to-back errors keep the first; err_clr with the third captures it
    vecs[24] = mk(32'h2000_0000, N, 2'b11, 2'b00, D, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 2'b00, 32'h0, 2'b00);
    vecs[25] = mk(32'h2000_0000, N, 2'b11, 2'b00, D, 1'b0, 1'b0, 1'b1, 32'h0, 2'b00, 1'b0, 2'b00, 32'h0, 2'b00);
    vecs[26] = mk(32'h3000_0000, N, 2'b11, 2'b00, D, 1'b0, 1'b1, 1'b1, 32'h0, 2'b00, 1'b1, 2'b01, 32'h2000_0000, 2'b00);
    vecs[27] = mk(32'h3000_0000, N, 2'b11, 2'b00, D, 1'b0, 1'b0, 1'b1, 32'h0, 2'b00, 1'b1, 2'b01, 32'h2000_0000, 2'b00);
    vecs[28] = mk(32'h4000_0000, N, 2'b11, 2'b00, D, 1'b0, 1'b1, 1'b1, 32'h0, 2'b00, 1'b1, 2'b01, 32'h2000_0000, 2'b00);
    vecs[29] = mk(32'h4000_0000, N, 2'b11, 2'b00, D, 1'b1, 1'b0, 1'b1, 32'h0, 2'b00, 1'b1, 2'b01, 32'h2000_0000, 2'b00);
    vecs[30] = mk(32'h4000_0000, I, 2'b11, 2'b00, D, 1'b0, 1'b1, 1'b1, 32'h0, 2'b00, 1'b1, 2'b01, 32'h4000_0000, 2'b00);
    // slave0 two-cycle ERROR response
    vecs[31] = mk(32'h100, N, 2'b11, 2'b00, D, 1'b1, 1'b1, 1'b0, 32'h0, 2'b01, 1'b1, 2'b01, 32'h4000_0000, 2'b00);
    vecs[32] = mk(32'h100, I, 2'b10, 2'b01, D, 1'b0, 1'b0, 1'b1, D,     2'b01, 1'b0, 2'b00, 32'h0, 2'b00);
    vecs[33] = mk(32'h100, I, 2'b11, 2'b01, D, 1'b0, 1'b1, 1'b1, D,     2'b01, 1'b1, 2'b11, 32'h100, 2'b00);
    vecs[34] = mk(32'h100, I, 2'b11, 2'b00, D, 1'b0, 1'b1, 1'b0, 32'h0, 2'b01, 1'b1, 2'b11, 32'h100, 2'b00);

    HRESETn = 1'b0; M_HWRITE = 1'b0; M_HSIZE = 3'b010; M_HWDATA = 32'h0BAD_BEEF;
    drive(32'h0, I, 2'b11, 2'b00, D, 1'b0);
    #2;
    chk("rst hready", {31'h0, M_HREADY}, 32'h1);
    chk("rst hresp",  {31'h0, M_HRESP},  32'h0);
    chk("rst hrdata", M_HRDATA, 32'h0);
    chk("rst err",    {29'h0, err_valid, err_type}, 32'h0);
    chk("rst eaddr",  err_addr, 32'h0);
    chk("rst quar",   {30'h0, quarantine}, 32'h0);
    chk("hwdata bcast", S_HWDATA, 32'h0BAD_BEEF);
    @(negedge HCLK);
    HRESETn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge HCLK);
      drive(vecs[i].addr, vecs[i].trans, vecs[i].rdy, vecs[i].resp, vecs[i].rd, vecs[i].clr);
      #1;
      chk($sformatf("v%0d hready", i), {31'h0, M_HREADY},   {31'h0, vecs[i].e_rdy});
      chk($sformatf("v%0d hresp", i),  {31'h0, M_HRESP},    {31'h0, vecs[i].e_resp});
      chk($sformatf("v%0d hrdata", i), M_HRDATA,            vecs[i].e_rdata);
      chk($sformatf("v%0d hsel", i),   {30'h0, S_HSEL},     {30'h0, vecs[i].e_hsel});
      chk($sformatf("v%0d errv", i),   {31'h0, err_valid},  {31'h0, vecs[i].e_ev});
      chk($sformatf("v%0d errt", i),   {30'h0, err_type},   {30'h0, vecs[i].e_et});
      chk($sformatf("v%0d eaddr", i),  err_addr,            vecs[i].e_ea);
      chk($sformatf("v%0d quar", i),   {30'h0, quarantine}, {30'h0, vecs[i].e_q});
      chk($sformatf("v%0d sready", i), {31'h0, S_HREADY},   {31'h0, vecs[i].e_rdy});
    end

    // reset asserted while in ERR1
    @(negedge HCLK);
    drive(32'h2000_0000, N, 2'b11, 2'b00, D, 1'b0);
    @(negedge HCLK);
    drive(32'h2000_0000, I, 2'b11, 2'b00, D, 1'b0);
    #1;
    chk("err1 hready", {31'h0, M_HREADY}, 32'h0);
    chk("err1 hresp",  {31'h0, M_HRESP},  32'h1);
    HRESETn = 1'b0;
    #1;
    chk("rstmid hready", {31'h0, M_HREADY}, 32'h1);
    chk("rstmid hresp",  {31'h0, M_HRESP},  32'h0);
    chk("rstmid errv",   {31'h0, err_valid}, 32'h0);
    @(negedge HCLK);
    chk("rstmid2 hready", {31'h0, M_HREADY}, 32'h1);
    chk("rstmid2 err",    {29'h0, err_valid, err_type}, 32'h0);
    HRESETn = 1'b1;

    // overlapping regions resolve to the lowest index
    @(negedge HCLK);
    drive(32'h10, I, 2'b11, 2'b00, D, 1'b0);
    #1;
    chk("ovl hsel 0x10", {30'h0, o_hsel}, 32'h1);
    M_HADDR = 32'h0000_0800;
    #1;
    chk("ovl hsel 0x800", {30'h0, o_hsel}, 32'h1);
    M_HADDR = 32'h1000_0000;
    #1;
    chk("ovl hsel 0x10000000", {30'h0, o_hsel}, 32'h0);
    chk("main hsel 0x10000000", {30'h0, S_HSEL}, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
